// File: rtl/letc_trace_pkg.sv
// Shared types for the LETC commit tracer: retire record, stamped trace record, tracer state.
package letc_trace_pkg;

    // Width of the seq field carried in trace_rec_t; the tracer's SEQ_W must not exceed it.
    localparam int TRACE_SEQ_W = 32;

    typedef struct packed {
        logic [31:0] pc;
        logic        rd_we;
        logic [4:0]  rd_idx;
        logic [31:0] rd_val;
    } commit_rec_t;

    typedef struct packed {
        logic [TRACE_SEQ_W-1:0] seq;
        commit_rec_t            rec;
    } trace_rec_t;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        DRAIN = 2'd1,
        DONE  = 2'd2
    } trace_state_e;

endpackage

// File: rtl/letc_trace_mpfifo.sv
// Multi-push / single-pop FIFO. Pushes arrive compacted in slots 0..push_cnt-1, oldest first.
module letc_trace_mpfifo #(
    parameter int  DEPTH    = 16,
    parameter int  NUM_PUSH = 1,
    parameter type T        = logic [7:0]
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic [$clog2(NUM_PUSH+1)-1:0]    push_cnt_i,
    input  T     [NUM_PUSH-1:0]              push_data_i,
    input  logic                             overwrite_i,
    input  logic                             pop_ready_i,
    output logic                             head_valid_o,
    output T                                 head_o,
    output logic [$clog2(DEPTH+1)-1:0]       level_o,
    output logic [$clog2(DEPTH+1)-1:0]       level_next_o,
    output logic [$clog2(NUM_PUSH+1)-1:0]    lost_o
);
    localparam int PW = $clog2(DEPTH);
    localparam int LW = $clog2(DEPTH+1);
    localparam int CW = $clog2(NUM_PUSH+1);

    T                mem_q [DEPTH];
    logic [PW-1:0]   rd_ptr_q, rd_ptr_d, wr_ptr;
    logic [LW-1:0]   level_q, level_d;
    int              acc;

    // Write pointer is derived from the head and occupancy; DEPTH is a power of two so it wraps.
    assign wr_ptr       = rd_ptr_q + PW'(level_q);
    assign head_valid_o = (level_q != '0);
    assign head_o       = head_valid_o ? mem_q[rd_ptr_q] : '0;
    assign level_o      = level_q;
    assign level_next_o = level_d;

    always_comb begin
        int lvl, n, pop, space, disc, lost;
        lvl   = int'(level_q);
        n     = int'(push_cnt_i);
        pop   = (head_valid_o && pop_ready_i) ? 1 : 0;
        space = DEPTH - lvl + pop;
        if (!overwrite_i) begin
            acc  = (n < space) ? n : space;
            disc = 0;
            lost = n - acc;
        end else begin
            acc  = n;
            disc = lvl - pop + n - DEPTH;
            if (disc < 0) disc = 0;
            lost = disc;
        end
        rd_ptr_d = rd_ptr_q + PW'(pop + disc);
        level_d  = LW'(lvl - pop - disc + acc);
        lost_o   = CW'(lost);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

    // Storage needs no reset: reads are gated by occupancy.
    always_ff @(posedge clk) begin
        for (int i = 0; i < NUM_PUSH; i++) begin
            if (rst_n && (i < acc)) mem_q[wr_ptr + PW'(i)] <= push_data_i[i];
        end
    end

endmodule

// File: rtl/letc_commit_tracer.sv
// Commit-trace capture: filter and stamp retire records, buffer them, and sequence end-of-run.
module letc_commit_tracer
    import letc_trace_pkg::*;
#(
    parameter int NUM_CH          = 1,
    parameter int DEPTH           = 16,
    parameter int SEQ_W           = 32,
    parameter int DROP_W          = 16,
    parameter int WATCHDOG_CYCLES = 0
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [NUM_CH-1:0]            i_commit_valid,
    input  commit_rec_t [NUM_CH-1:0]     i_commit,
    input  logic                         i_exit,
    input  logic                         i_writes_only,
    input  logic                         i_overwrite,
    output logic                         o_rec_valid,
    input  logic                         i_rec_ready,
    output trace_rec_t                   o_rec,
    output logic [$clog2(DEPTH+1)-1:0]   o_level,
    output logic [DROP_W-1:0]            o_drop_count,
    output logic                         o_done,
    output logic                         o_hang,
    output trace_state_e                 o_state
);
    localparam int CW   = $clog2(NUM_CH+1);
    localparam int LW   = $clog2(DEPTH+1);
    localparam int WD_W = (WATCHDOG_CYCLES > 0) ? $clog2(WATCHDOG_CYCLES+1) : 1;

    trace_state_e                state_q, state_d;
    logic [SEQ_W-1:0]            seq_q, seq_d;
    logic [DROP_W-1:0]           drop_q, drop_d;
    logic [WD_W-1:0]             wd_q, wd_d;
    logic                        hang_q, wd_fire;
    trace_rec_t [NUM_CH-1:0]     push_data;
    logic [CW-1:0]               push_cnt;
    logic [CW-1:0]               lost;
    logic [LW-1:0]               level_next;
    logic [DROP_W:0]             drop_sum;

    // Compact eligible channels into consecutive push slots, stamping in channel order.
    always_comb begin
        int          n;
        commit_rec_t norm;
        n         = 0;
        push_data = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            norm = i_commit[k];
            if (norm.rd_idx == 5'd0) norm.rd_we = 1'b0;
            if (state_q == RUN && i_commit_valid[k] && (!i_writes_only || norm.rd_we)) begin
                push_data[n].seq = TRACE_SEQ_W'(seq_q + SEQ_W'(n));
                push_data[n].rec = norm;
                n++;
            end
        end
        push_cnt = CW'(n);
        seq_d    = seq_q + SEQ_W'(n);
    end

    letc_trace_mpfifo #(
        .DEPTH    (DEPTH),
        .NUM_PUSH (NUM_CH),
        .T        (trace_rec_t)
    ) u_fifo (
        .clk          (clk),
        .rst_n        (rst_n),
        .push_cnt_i   (push_cnt),
        .push_data_i  (push_data),
        .overwrite_i  (i_overwrite),
        .pop_ready_i  (i_rec_ready),
        .head_valid_o (o_rec_valid),
        .head_o       (o_rec),
        .level_o      (o_level),
        .level_next_o (level_next),
        .lost_o       (lost)
    );

    assign drop_sum = {1'b0, drop_q} + (DROP_W+1)'(lost);
    assign drop_d   = drop_sum[DROP_W] ? '1 : drop_sum[DROP_W-1:0];

    always_comb begin
        wd_d    = wd_q;
        wd_fire = 1'b0;
        if (WATCHDOG_CYCLES != 0 && state_q == RUN) begin
            if (|i_commit_valid) begin
                wd_d = '0;
            end else begin
                wd_d    = wd_q + 1'b1;
                wd_fire = (int'(wd_d) == WATCHDOG_CYCLES);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= RUN;
            seq_q   <= '0;
            drop_q  <= '0;
            wd_q    <= '0;
            hang_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            seq_q   <= seq_d;
            drop_q  <= drop_d;
            wd_q    <= wd_d;
            hang_q  <= hang_q | wd_fire;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            RUN:     if (i_exit || wd_fire) state_d = DRAIN;
            DRAIN:   if (level_next == '0)  state_d = DONE;
            DONE:    state_d = DONE;
            default: state_d = RUN;
        endcase
    end

    always_comb begin
        o_done       = (state_q == DONE);
        o_hang       = hang_q;
        o_drop_count = drop_q;
        o_state      = state_q;
    end

endmodule

// File: tb/tb_letc_commit_tracer.sv
// Directed and randomized bench for letc_commit_tracer against a queue-based reference model.
module tb_letc_commit_tracer;
    import letc_trace_pkg::*;

    localparam int NCH = 2;
    localparam int DEP = 4;
    localparam int TW  = $bits(trace_rec_t);

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    // Main DUT (watchdog off) stimulus and outputs
    logic [NCH-1:0]        cv;
    commit_rec_t [NCH-1:0] cr;
    logic                  ex, wo, ow, rdy;
    logic                  o_rec_valid, o_done, o_hang;
    trace_rec_t            o_rec;
    logic [2:0]            o_level;
    logic [15:0]           o_drop;
    trace_state_e          o_state;

    // Watchdog DUT stimulus and outputs
    logic [NCH-1:0]        wcv;
    commit_rec_t [NCH-1:0] wcr;
    logic                  w_valid, w_done, w_hang;
    trace_rec_t            w_rec;
    logic [2:0]            w_level;
    logic [15:0]           w_drop;
    trace_state_e          w_state;

    letc_commit_tracer #(.NUM_CH(NCH), .DEPTH(DEP), .SEQ_W(32), .DROP_W(16), .WATCHDOG_CYCLES(0)) dut (
        .clk(clk), .rst_n(rst_n), .i_commit_valid(cv), .i_commit(cr), .i_exit(ex),
        .i_writes_only(wo), .i_overwrite(ow), .o_rec_valid(o_rec_valid), .i_rec_ready(rdy),
        .o_rec(o_rec), .o_level(o_level), .o_drop_count(o_drop), .o_done(o_done),
        .o_hang(o_hang), .o_state(o_state)
    );

    letc_commit_tracer #(.NUM_CH(NCH), .DEPTH(DEP), .SEQ_W(32), .DROP_W(16), .WATCHDOG_CYCLES(8)) dut_wd (
        .clk(clk), .rst_n(rst_n), .i_commit_valid(wcv), .i_commit(wcr), .i_exit(1'b0),
        .i_writes_only(1'b0), .i_overwrite(1'b0), .o_rec_valid(w_valid), .i_rec_ready(1'b1),
        .o_rec(w_rec), .o_level(w_level), .o_drop_count(w_drop), .o_done(w_done),
        .o_hang(w_hang), .o_state(w_state)
    );

    // Reference model
    logic [TW-1:0] exp_q[$];
    logic [31:0]   m_seq;
    int            m_drop;
    int            m_phase;   // 0 running, 1 draining, 2 done

    int checks = 0;
    int passes = 0;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic model_edge();
        trace_rec_t  t;
        commit_rec_t r;
        logic [TW-1:0] caps[$];
        int old_phase;
        if (!rst_n) begin
            exp_q.delete();
            m_seq = 0; m_drop = 0; m_phase = 0;
            return;
        end
        old_phase = m_phase;
        if (exp_q.size() != 0 && rdy) void'(exp_q.pop_front());
        for (int k = 0; k < NCH; k++) begin
            r = cr[k];
            if (r.rd_idx == 0) r.rd_we = 1'b0;
            if (old_phase == 0 && cv[k] && (!wo || r.rd_we)) begin
                t.seq = m_seq;
                t.rec = r;
                m_seq = m_seq + 1;
                caps.push_back(t);
            end
        end
        foreach (caps[i]) begin
            if (ow) begin
                exp_q.push_back(caps[i]);
                if (exp_q.size() > DEP) begin
                    void'(exp_q.pop_front());
                    m_drop++;
                end
            end else if (exp_q.size() < DEP) begin
                exp_q.push_back(caps[i]);
            end else begin
                m_drop++;
            end
        end
        if (m_drop > 65535) m_drop = 65535;
        if (old_phase == 0 && ex) m_phase = 1;
        else if (old_phase == 1 && exp_q.size() == 0) m_phase = 2;
    endtask

    task automatic check_main();
        chk("rec_valid", o_rec_valid, exp_q.size() != 0);
        chk("rec", o_rec, (exp_q.size() != 0) ? exp_q[0] : '0);
        chk("level", o_level, exp_q.size());
        chk("drop", o_drop, m_drop);
        chk("done", o_done, m_phase == 2);
        chk("hang", o_hang, 1'b0);
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        check_main();
    endtask

    task automatic set_rec(input int k, input logic [31:0] pc, input logic we,
                           input logic [4:0] idx, input logic [31:0] val);
        cr[k].pc = pc; cr[k].rd_we = we; cr[k].rd_idx = idx; cr[k].rd_val = val;
    endtask

    task automatic do_reset();
        rst_n = 1'b0; cv = '0; ex = 1'b0; wo = 1'b0; ow = 1'b0; wcv = '0;
        step();
        rst_n = 1'b1;
    endtask

    task automatic push_one(input logic [31:0] pc);
        cv = 2'b01;
        set_rec(0, pc, 1'b1, 5'd1, pc ^ 32'h5A5A_0000);
        step();
        cv = '0;
    endtask

    initial begin
        cv = '0; cr = '0; ex = 0; wo = 0; ow = 0; rdy = 0; wcv = '0; wcr = '0; rst_n = 0;

        // Reset state
        do_reset();
        chk("rst_state", o_state, RUN);
        chk("rst_wd_hang", w_hang, 1'b0);

        // Two records in one cycle, stamped in channel order
        rdy = 1;
        cv = 2'b11;
        set_rec(0, 32'h100, 1'b1, 5'd5, 32'hAA);
        set_rec(1, 32'h104, 1'b0, 5'd0, 32'h0);
        step();
        cv = '0;
        chk("t1_seq0", o_rec.seq, 0);
        chk("t1_pc0", o_rec.rec.pc, 32'h100);
        chk("t1_level", o_level, 2);
        step();
        chk("t1_seq1", o_rec.seq, 1);
        chk("t1_pc1", o_rec.rec.pc, 32'h104);
        chk("t1_we1", o_rec.rec.rd_we, 1'b0);
        step();

        // Writes-only filter: x0 write is not a real write
        do_reset();
        rdy = 0; wo = 1;
        cv = 2'b11;
        set_rec(0, 32'h200, 1'b1, 5'd0, 32'h11);
        set_rec(1, 32'h204, 1'b1, 5'd3, 32'h22);
        step();
        chk("wo_level", o_level, 1);
        chk("wo_seq", o_rec.seq, 0);
        chk("wo_pc", o_rec.rec.pc, 32'h204);
        cv = 2'b01;
        set_rec(0, 32'h208, 1'b1, 5'd7, 32'h33);
        step();
        cv = '0; wo = 0; rdy = 1;
        step();
        chk("wo_seq_next", o_rec.seq, 1);
        step();

        // Drop-newest when full
        do_reset();
        rdy = 0; ow = 0;
        for (int i = 0; i < 6; i++) push_one(32'h300 + 4 * i);
        chk("dn_level", o_level, 4);
        chk("dn_drop", o_drop, 2);
        chk("dn_head", o_rec.seq, 0);
        rdy = 1;
        for (int i = 0; i < 4; i++) step();

        // Discard-oldest when full
        do_reset();
        rdy = 0; ow = 1;
        for (int i = 0; i < 6; i++) push_one(32'h400 + 4 * i);
        chk("ow_level", o_level, 4);
        chk("ow_drop", o_drop, 2);
        chk("ow_head", o_rec.seq, 2);
        rdy = 1;
        for (int i = 0; i < 4; i++) step();

        // Full FIFO, pop plus two pushes with drop-newest
        do_reset();
        rdy = 0; ow = 0;
        for (int i = 0; i < 4; i++) push_one(32'h500 + 4 * i);
        rdy = 1; cv = 2'b11;
        set_rec(0, 32'h600, 1'b1, 5'd2, 32'h1);
        set_rec(1, 32'h604, 1'b1, 5'd3, 32'h2);
        step();
        cv = '0; rdy = 0;
        chk("full_level", o_level, 4);
        chk("full_drop", o_drop, 1);
        rdy = 1;
        for (int i = 0; i < 4; i++) step();

        // Randomized traffic
        do_reset();
        for (int i = 0; i < 400; i++) begin
            cv  = 2'($urandom_range(0, 3));
            for (int k = 0; k < NCH; k++)
                set_rec(k, $urandom, 1'($urandom_range(0, 1)),
                        ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom_range(1, 31)), $urandom);
            wo  = ($urandom_range(0, 7) == 0);
            ow  = ((i / 50) % 2) == 1;
            rdy = ($urandom_range(0, 9) < 6);
            step();
        end
        cv = '0; rdy = 1; wo = 0; ow = 0;
        for (int i = 0; i < 5; i++) step();

        // Exit: same-cycle record captured, later ones ignored, done after drain
        do_reset();
        rdy = 0;
        for (int i = 0; i < 3; i++) push_one(32'h700 + 4 * i);
        ex = 1;
        push_one(32'h70C);
        ex = 0;
        chk("exit_level", o_level, 4);
        chk("exit_state", o_state, DRAIN);
        push_one(32'h710);
        ex = 1;
        step();
        ex = 0;
        chk("exit_ignored", o_level, 4);
        rdy = 1;
        for (int i = 0; i < 3; i++) step();
        chk("exit_not_done", o_done, 1'b0);
        step();
        chk("exit_done", o_done, 1'b1);
        step();
        chk("exit_sticky", o_done, 1'b1);

        // Reset with records buffered
        do_reset();
        rdy = 0;
        for (int i = 0; i < 3; i++) push_one(32'h800 + 4 * i);
        chk("mid_level", o_level, 3);
        do_reset();
        chk("mid_rst_level", o_level, 0);
        chk("mid_rst_valid", o_rec_valid, 1'b0);
        push_one(32'h900);
        chk("mid_rst_seq", o_rec.seq, 0);
        rdy = 1;
        step();

        // Watchdog: a commit at cycle 7 restarts the count
        do_reset();
        wcr = '0;
        wcr[0].pc = 32'hA00; wcr[0].rd_we = 1'b1; wcr[0].rd_idx = 5'd4;
        for (int i = 0; i < 7; i++) step();
        chk("wd_pre_hang", w_hang, 1'b0);
        wcv = 2'b01;
        step();
        wcv = '0;
        chk("wd_commit_level", w_level, 1);
        for (int i = 0; i < 7; i++) step();
        chk("wd_hang_7", w_hang, 1'b0);
        chk("wd_state_run", w_state, RUN);
        step();
        chk("wd_hang_8", w_hang, 1'b1);
        chk("wd_state_drain", w_state, DRAIN);
        chk("wd_done_early", w_done, 1'b0);
        step();
        chk("wd_done", w_done, 1'b1);
        chk("wd_hang_sticky", w_hang, 1'b1);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
